fp_vector_sequencer: RTL

//  Upstream stage of the 64x11 test-vector memory. Steps the memory address
//  0..NUM_VECTORS-1 and absorbs the memory's 1-cycle registered read latency.

---
 rtl/fp_vector_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fp_vector_sequencer.sv
// fp_vector_sequencer: walks the test-vector memory and hands each word
// to the FP adder as two single-precision operands over valid/ready.
// Ports:
//   clk, reset (synchronous, active-low), start (run request)
//   mem_address / mem_content   memory address out, read data in
//   op_a / op_b / op_valid      operands to the adder
//   op_ready                    adder accepts operands
//   vec_index, busy, done       run status
// Optional build macro FP_SEQ_LOOP_EN adds input `stop`; the run then
// repeats from vector 0 until stop is seen at a handshake.
module fp_vector_sequencer #(
    parameter int unsigned NUM_VECTORS = 11,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned OP_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef FP_SEQ_LOOP_EN
    input  logic              stop,
`endif
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_content,
    output logic [OP_W-1:0]   op_a,
    output logic [OP_W-1:0]   op_b,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [ADDR_W-1:0] vec_index,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_PRESENT,
        S_DONE
    } state_e;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_VECTORS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [OP_W-1:0]   a_q, a_d;
    logic [OP_W-1:0]   b_q, b_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hs;

    assign hs = valid_q & op_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        valid_d = valid_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            // Memory samples addr_q on the edge that leaves FETCH.
            S_FETCH: state_d = S_CAPTURE;
            S_CAPTURE: begin
                a_d     = mem_content[DATA_W-1 -: OP_W];
                b_d     = mem_content[OP_W-1:0];
                valid_d = 1'b1;
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (hs) begin
                    valid_d = 1'b0;
`ifdef FP_SEQ_LOOP_EN
                    if (stop) begin
                        state_d = S_DONE;
                    end else if (idx_q == LastIdx) begin
                        addr_d  = '0;
                        idx_d   = '0;
                        state_d = S_FETCH;
                    end else begin
`else
                    if (idx_q == LastIdx) begin
                        state_d = S_DONE;
                    end else begin
`endif
                        addr_d  = addr_q + ADDR_W'(1);
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Status flags are registered from the next state so they line
        // up with the state they describe.
        busy_d = (state_d == S_FETCH) || (state_d == S_CAPTURE)
              || (state_d == S_PRESENT);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mem_address = addr_q;
    assign vec_index   = idx_q;
    assign op_a        = a_q;
    assign op_b        = b_q;
    assign op_valid    = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
